// File: rtl/e203_exu_aluoitf_if.sv
// Dispatch / retire bundle of the outstanding-instruction tracking FIFO.
// The controller side drives requests; the FIFO drives status, itags and hazard flags.
interface e203_exu_aluoitf_if #(
    parameter int ITAG_WIDTH  = 2,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
);
    logic                   dis_ena;
    logic                   dis_ready;
    logic [ITAG_WIDTH-1:0]  dis_ptr;
    logic                   disp_i_rdwen;
    logic [RFIDX_WIDTH-1:0] disp_i_rdidx;
    logic [PC_SIZE-1:0]     disp_i_pc;
    logic                   disp_i_rs1en;
    logic                   disp_i_rs2en;
    logic [RFIDX_WIDTH-1:0] disp_i_rs1idx;
    logic [RFIDX_WIDTH-1:0] disp_i_rs2idx;
    logic                   oitfrd_match_disprs1;
    logic                   oitfrd_match_disprs2;
    logic                   oitfrd_match_disprd;
    logic                   ret_ena;
    logic                   oitf_empty;
    logic [ITAG_WIDTH-1:0]  ret_ptr;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic [PC_SIZE-1:0]     ret_pc;
    logic                   ret_rdwen;

    modport master (
        output dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_pc,
               disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx, ret_ena,
        input  dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
               oitfrd_match_disprd, oitf_empty, ret_ptr, ret_rdidx, ret_pc, ret_rdwen
    );

    modport slave (
        input  dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_pc,
               disp_i_rs1en, disp_i_rs2en, disp_i_rs1idx, disp_i_rs2idx, ret_ena,
        output dis_ready, dis_ptr, oitfrd_match_disprs1, oitfrd_match_disprs2,
               oitfrd_match_disprd, oitf_empty, ret_ptr, ret_rdidx, ret_pc, ret_rdwen
    );
endinterface

// File: rtl/e203_exu_aluoitf.sv
// In-order outstanding-instruction FIFO for the ALU long-latency write-back path,
// with combinational RAW/WAW hazard flags against every in-flight entry.
module e203_exu_aluoitf #(
    parameter int DEPTH       = 4,
    parameter int ITAG_WIDTH  = 2,
    parameter int RFIDX_WIDTH = 5,
    parameter int PC_SIZE     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    e203_exu_aluoitf_if.slave       oitf
);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [ITAG_WIDTH:0]    alc_ptr_q, alc_ptr_d;
    logic [ITAG_WIDTH:0]    ret_ptr_q, ret_ptr_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [DEPTH];
    logic [DEPTH-1:0]       rdwen_q;

    logic [ITAG_WIDTH-1:0]  alc_idx;
    logic [ITAG_WIDTH-1:0]  ret_idx;
    logic                   oitf_full;
    logic                   oitf_empty;
    logic                   alc_fire;
    logic                   ret_fire;
    logic                   hit_rs1;
    logic                   hit_rs2;
    logic                   hit_rd;

    assign alc_idx    = alc_ptr_q[ITAG_WIDTH-1:0];
    assign ret_idx    = ret_ptr_q[ITAG_WIDTH-1:0];
    assign oitf_empty = (alc_ptr_q == ret_ptr_q);
    assign oitf_full  = (alc_idx == ret_idx) && (alc_ptr_q[ITAG_WIDTH] != ret_ptr_q[ITAG_WIDTH]);

    // A slot freed by a same-cycle retire is deliberately not reusable until next cycle.
    assign alc_fire = oitf.dis_ena & ~oitf_full;
    assign ret_fire = oitf.ret_ena & ~oitf_empty;

    always_comb begin
        alc_ptr_d = alc_ptr_q;
        ret_ptr_d = ret_ptr_q;
        vld_d     = vld_q;
        if (alc_fire) begin
            alc_ptr_d        = alc_ptr_q + 1'b1;
            vld_d[alc_idx]   = 1'b1;
        end
        if (ret_fire) begin
            ret_ptr_d        = ret_ptr_q + 1'b1;
            vld_d[ret_idx]   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
            vld_q     <= '0;
            rdwen_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdidx_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            alc_ptr_q <= alc_ptr_d;
            ret_ptr_q <= ret_ptr_d;
            vld_q     <= vld_d;
            if (alc_fire) begin
                rdwen_q[alc_idx] <= oitf.disp_i_rdwen;
                rdidx_q[alc_idx] <= oitf.disp_i_rdidx;
                pc_q[alc_idx]    <= oitf.disp_i_pc;
            end
        end
    end

    // Entries retiring this cycle still count; x0 filtering is left to dispatch.
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_rs1 = hit_rs1 | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.disp_i_rs1idx));
            hit_rs2 = hit_rs2 | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.disp_i_rs2idx));
            hit_rd  = hit_rd  | (vld_q[i] & rdwen_q[i] & (rdidx_q[i] == oitf.disp_i_rdidx));
        end
    end

    assign oitf.oitfrd_match_disprs1 = hit_rs1 & oitf.disp_i_rs1en;
    assign oitf.oitfrd_match_disprs2 = hit_rs2 & oitf.disp_i_rs2en;
    assign oitf.oitfrd_match_disprd  = hit_rd  & oitf.disp_i_rdwen;

    assign oitf.dis_ready  = ~oitf_full;
    assign oitf.dis_ptr    = alc_idx;
    assign oitf.oitf_empty = oitf_empty;
    assign oitf.ret_ptr    = ret_idx;
    assign oitf.ret_rdidx  = rdidx_q[ret_idx];
    assign oitf.ret_pc     = pc_q[ret_idx];
    assign oitf.ret_rdwen  = rdwen_q[ret_idx];

endmodule

// File: tb/tb_e203_exu_aluoitf.sv
// Scoreboard bench for the OITF: directed fill/drain/wrap/hazard cases, then random traffic.
module tb_e203_exu_aluoitf;
    localparam int DEPTH = 4;
    localparam int IW    = 2;
    localparam int RW    = 5;
    localparam int PW    = 32;

    typedef struct {
        logic          rdwen;
        logic [RW-1:0] rdidx;
        logic [PW-1:0] pc;
        int            itag;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   alc_cnt = 0;
    int   ret_cnt = 0;
    ent_t mdl[$];
    ent_t sb_q[$];

    e203_exu_aluoitf_if #(.ITAG_WIDTH(IW), .RFIDX_WIDTH(RW), .PC_SIZE(PW)) bus ();

    e203_exu_aluoitf #(.DEPTH(DEPTH), .ITAG_WIDTH(IW), .RFIDX_WIDTH(RW), .PC_SIZE(PW)) dut (
        .clk  (clk),
        .rst  (rst),
        .oitf (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_disp(input logic rdwen, input logic [RW-1:0] rdidx, input logic [PW-1:0] pc,
                            input logic rs1en, input logic [RW-1:0] rs1, input logic rs2en,
                            input logic [RW-1:0] rs2);
        bus.disp_i_rdwen  = rdwen;
        bus.disp_i_rdidx  = rdidx;
        bus.disp_i_pc     = pc;
        bus.disp_i_rs1en  = rs1en;
        bus.disp_i_rs1idx = rs1;
        bus.disp_i_rs2en  = rs2en;
        bus.disp_i_rs2idx = rs2;
    endtask

    // One cycle: drive, check against the model at negedge, advance the model, return at posedge+1.
    task automatic step(input bit a, input bit r);
        bit   acc, rt, h1, h2, hd;
        ent_t e;
        bus.dis_ena = a;
        bus.ret_ena = r && (mdl.size() > 0);
        @(negedge clk);
        chk("dis_ready",  bus.dis_ready,  mdl.size() < DEPTH);
        chk("oitf_empty", bus.oitf_empty, mdl.size() == 0);
        chk("dis_ptr",    bus.dis_ptr,    alc_cnt % DEPTH);
        chk("ret_ptr",    bus.ret_ptr,    ret_cnt % DEPTH);
        h1 = 0; h2 = 0; hd = 0;
        foreach (mdl[k]) begin
            if (mdl[k].rdwen && mdl[k].rdidx == bus.disp_i_rs1idx) h1 = 1;
            if (mdl[k].rdwen && mdl[k].rdidx == bus.disp_i_rs2idx) h2 = 1;
            if (mdl[k].rdwen && mdl[k].rdidx == bus.disp_i_rdidx)  hd = 1;
        end
        chk("match_rs1", bus.oitfrd_match_disprs1, h1 && bus.disp_i_rs1en);
        chk("match_rs2", bus.oitfrd_match_disprs2, h2 && bus.disp_i_rs2en);
        chk("match_rd",  bus.oitfrd_match_disprd,  hd && bus.disp_i_rdwen);
        if (mdl.size() > 0) begin
            chk("head_pc",    bus.ret_pc,    mdl[0].pc);
            chk("head_rdidx", bus.ret_rdidx, mdl[0].rdidx);
            chk("head_rdwen", bus.ret_rdwen, mdl[0].rdwen);
        end
        acc = a && (mdl.size() < DEPTH);
        rt  = bus.ret_ena;
        if (rt) begin
            void'(mdl.pop_front());
            ret_cnt++;
        end
        if (acc) begin
            e.rdwen = bus.disp_i_rdwen;
            e.rdidx = bus.disp_i_rdidx;
            e.pc    = bus.disp_i_pc;
            e.itag  = alc_cnt % DEPTH;
            mdl.push_back(e);
            sb_q.push_back(e);
            alc_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // Retire monitor: every retire the bench issues must present the oldest outstanding entry.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && bus.ret_ena) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_underflow actual=retire required=entry_outstanding at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("mon_nonempty", bus.oitf_empty, 1'b0);
                chk("mon_pc",       bus.ret_pc,     e.pc);
                chk("mon_rdidx",    bus.ret_rdidx,  e.rdidx);
                chk("mon_rdwen",    bus.ret_rdwen,  e.rdwen);
                chk("mon_itag",     bus.ret_ptr,    e.itag);
            end
        end
    end

    task automatic reset_values(input string tag);
        chk({tag, "_ready"},  bus.dis_ready,  1'b1);
        chk({tag, "_empty"},  bus.oitf_empty, 1'b1);
        chk({tag, "_disptr"}, bus.dis_ptr,    0);
        chk({tag, "_retptr"}, bus.ret_ptr,    0);
        chk({tag, "_retpc"},  bus.ret_pc,     0);
        chk({tag, "_rdidx"},  bus.ret_rdidx,  0);
        chk({tag, "_rdwen"},  bus.ret_rdwen,  0);
        chk({tag, "_m1"},     bus.oitfrd_match_disprs1, 1'b0);
        chk({tag, "_m2"},     bus.oitfrd_match_disprs2, 1'b0);
        chk({tag, "_md"},     bus.oitfrd_match_disprd,  1'b0);
    endtask

    task automatic rand_step();
        set_disp($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7));
        step($urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    initial begin
        bus.dis_ena = 0;
        bus.ret_ena = 0;
        set_disp(1, 0, 0, 1, 0, 1, 0);
        #2;
        reset_values("rst");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Fill with four entries, then a fifth request that must be ignored.
        for (int i = 0; i < 4; i++) begin
            set_disp(1, 5'(i + 1), 32'h100 + 32'(4 * i), 0, 0, 0, 0);
            chk("fill_ptr", bus.dis_ptr, i);
            step(1, 0);
        end
        chk("fill_full", bus.dis_ready, 1'b0);
        set_disp(1, 9, 32'h200, 0, 0, 0, 0);
        step(1, 0);
        chk("fifth_pc",  bus.ret_pc,  32'h100);
        chk("fifth_ptr", bus.ret_ptr, 0);

        // In-order drain.
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", bus.ret_pc, 32'h100 + 32'(4 * i));
            step(0, 1);
        end
        chk("drain_empty", bus.oitf_empty, 1'b1);

        // Wrap-around with alternating allocate/retire.
        for (int i = 0; i < 6; i++) begin
            set_disp(1, 5'(i), 32'h300 + 32'(4 * i), 0, 0, 0, 0);
            chk("wrap_ptr", bus.dis_ptr, i % 4);
            step(1, 0);
            chk("wrap_pc", bus.ret_pc, 32'h300 + 32'(4 * i));
            step(0, 1);
        end

        // Full with simultaneous allocate and retire: only the retire lands.
        for (int i = 0; i < 4; i++) begin
            set_disp(1, 5'(i + 10), 32'h400 + 32'(4 * i), 0, 0, 0, 0);
            step(1, 0);
        end
        set_disp(1, 20, 32'h500, 0, 0, 0, 0);
        step(1, 1);
        chk("simul_ready", bus.dis_ready, 1'b1);
        chk("simul_count", 2'(bus.dis_ptr - bus.ret_ptr), 3);
        for (int i = 0; i < 3; i++) step(0, 1);

        // Hazard flags against a single in-flight entry.
        set_disp(1, 7, 32'h600, 0, 0, 0, 0);
        step(1, 0);
        set_disp(0, 3, 0, 1, 7, 0, 0);
        #1 chk("haz_rs1_hit", bus.oitfrd_match_disprs1, 1'b1);
        bus.disp_i_rs1en = 0;
        #1 chk("haz_rs1_dis", bus.oitfrd_match_disprs1, 1'b0);
        set_disp(1, 7, 0, 0, 0, 0, 0);
        #1 chk("haz_waw", bus.oitfrd_match_disprd, 1'b1);
        step(0, 1);
        set_disp(0, 7, 32'h604, 0, 0, 0, 0);
        step(1, 0);
        set_disp(1, 7, 0, 1, 7, 1, 7);
        #1;
        chk("haz_nowr_rs1", bus.oitfrd_match_disprs1, 1'b0);
        chk("haz_nowr_rs2", bus.oitfrd_match_disprs2, 1'b0);
        chk("haz_nowr_rd",  bus.oitfrd_match_disprd,  1'b0);
        step(0, 1);

        for (int i = 0; i < 400; i++) rand_step();

        // Reset mid-fill: outputs must clear without any clock edge.
        while (mdl.size() > 2) step(0, 1);
        set_disp(1, 1, 32'h700, 0, 0, 0, 0);
        step(1, 0);
        bus.dis_ena = 0;
        bus.ret_ena = 0;
        set_disp(1, 0, 0, 1, 0, 1, 0);
        rst = 1;
        #1;
        reset_values("midrst");
        mdl.delete();
        sb_q.delete();
        alc_cnt = 0;
        ret_cnt = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 100; i++) rand_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
